// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
package bru_pkg;

  localparam int unsigned DefaultDepth = 4;
  localparam int unsigned DefaultPcInc = 4;

  // One in-flight prediction as recorded at decode.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bru_entry_t;

  localparam int unsigned EntryW = $bits(bru_entry_t);

  // Ceiling log2, used for pointer widths (returns 0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/bru_fifo.sv
// In-order circular buffer of predicted branches with synchronous flush.
module bru_fifo
  import bru_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned PtrW = clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  bru_entry_t       wdata,
  output bru_entry_t       rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  bru_entry_t      mem_q [DEPTH];

  logic push_ok, pop_ok;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // Flush drops any same-cycle push; overflow pushes are ignored.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + CntW'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CntW'(1);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues decode predictions, checks them against
// execute outcomes, drives predictor updates and mispredict redirects.
// Optional statistics counters are built when BRU_STATS_EN is defined.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter int unsigned PC_INC = DefaultPcInc,
  localparam int unsigned CntW  = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [31:0]      pred_pc,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic [31:0]      resolve_target,
  output logic             update_valid,
  output logic [31:0]      update_addr,
  output logic             update_taken,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CntW-1:0]  pending,
  output logic             underflow_err,
  output logic [15:0]      stat_resolved,
  output logic [15:0]      stat_mispred
);

  bru_entry_t wr_entry, head;
  logic       full, empty, pop_en, mispred_now, flush;

  logic        update_valid_q, update_valid_d;
  logic [31:0] update_addr_q, update_addr_d;
  logic        update_taken_q, update_taken_d;
  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        underflow_q, underflow_d;

  assign wr_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target};
  assign pop_en   = resolve_valid && !empty;

  // Wrong direction, or right direction (taken) but wrong target.
  assign mispred_now = (head.taken != resolve_taken) ||
                       (head.taken && resolve_taken && (head.target != resolve_target));
  assign flush = pop_en && mispred_now;

  bru_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pred_valid),
    .pop   (pop_en),
    .flush (flush),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

  assign pred_ready = !full;

  // Resolution outputs next-state; address/redirect hold between events.
  always_comb begin
    update_valid_d = pop_en;
    update_addr_d  = pop_en ? head.pc : update_addr_q;
    update_taken_d = pop_en ? resolve_taken : update_taken_q;
    mispredict_d   = flush;
    redirect_pc_d  = redirect_pc_q;
    if (flush) begin
      redirect_pc_d = resolve_taken ? resolve_target : (head.pc + PC_INC[31:0]);
    end
    underflow_d = underflow_q || (resolve_valid && empty);
  end

  // Registered resolution outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_valid_q <= 1'b0;
      update_addr_q  <= '0;
      update_taken_q <= 1'b0;
      mispredict_q   <= 1'b0;
      redirect_pc_q  <= '0;
      underflow_q    <= 1'b0;
    end else begin
      update_valid_q <= update_valid_d;
      update_addr_q  <= update_addr_d;
      update_taken_q <= update_taken_d;
      mispredict_q   <= mispredict_d;
      redirect_pc_q  <= redirect_pc_d;
      underflow_q    <= underflow_d;
    end
  end

  assign update_valid  = update_valid_q;
  assign update_addr   = update_addr_q;
  assign update_taken  = update_taken_q;
  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_pc_q;
  assign underflow_err = underflow_q;

`ifdef BRU_STATS_EN
  logic [15:0] stat_resolved_q, stat_resolved_d;
  logic [15:0] stat_mispred_q, stat_mispred_d;

  // Saturating counters that follow the registered strobes.
  always_comb begin
    stat_resolved_d = stat_resolved_q;
    stat_mispred_d  = stat_mispred_q;
    if (update_valid_q && (stat_resolved_q != 16'hFFFF)) stat_resolved_d = stat_resolved_q + 16'd1;
    if (mispredict_q && (stat_mispred_q != 16'hFFFF))     stat_mispred_d  = stat_mispred_q + 16'd1;
  end

  // Statistics state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`else
  assign stat_resolved = 16'h0000;
  assign stat_mispred  = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (DEPTH=4, PC_INC=4).
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        pred_valid;
  logic        pred_ready;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        update_valid;
  logic [31:0] update_addr;
  logic        update_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [2:0]  pending;
  logic        underflow_err;
  logic [15:0] stat_resolved;
  logic [15:0] stat_mispred;

  int unsigned n_total;
  int unsigned n_pass;

  branch_resolve_unit #(
    .DEPTH  (4),
    .PC_INC (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_valid     (pred_valid),
    .pred_ready     (pred_ready),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .update_valid   (update_valid),
    .update_addr    (update_addr),
    .update_taken   (update_taken),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .pending        (pending),
    .underflow_err  (underflow_err),
    .stat_resolved  (stat_resolved),
    .stat_mispred   (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // All drive tasks start and end on a falling edge.
  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tg;
    @(negedge clk);
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tg);
    resolve_valid = 1'b1; resolve_taken = tk; resolve_target = tg;
    @(negedge clk);
    resolve_valid = 1'b0;
  endtask

  task automatic push_and_resolve(input logic [31:0] pc, input logic ptk, input logic [31:0] ptg,
                                  input logic rtk, input logic [31:0] rtg);
    pred_valid = 1'b1; pred_pc = pc; pred_taken = ptk; pred_target = ptg;
    resolve_valid = 1'b1; resolve_taken = rtk; resolve_target = rtg;
    @(negedge clk);
    pred_valid = 1'b0;
    resolve_valid = 1'b0;
  endtask

  logic [31:0] wrap_pcs [4];

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
    wrap_pcs[0] = 32'h1000; wrap_pcs[1] = 32'h1100;
    wrap_pcs[2] = 32'h1200; wrap_pcs[3] = 32'h1300;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_pred_ready", 32'(pred_ready), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_update_valid", 32'(update_valid), 32'd0);
    check("rst_update_addr", update_addr, 32'd0);
    check("rst_mispredict", 32'(mispredict), 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_underflow", 32'(underflow_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct taken prediction.
    push(32'h100, 1'b1, 32'h140);
    check("t1_pending", 32'(pending), 32'd1);
    resolve(1'b1, 32'h140);
    check("t1_update_valid", 32'(update_valid), 32'd1);
    check("t1_update_addr", update_addr, 32'h100);
    check("t1_update_taken", 32'(update_taken), 32'd1);
    check("t1_mispredict", 32'(mispredict), 32'd0);
    check("t1_pending_after", 32'(pending), 32'd0);
    @(negedge clk);
    check("t1_strobe_one_cycle", 32'(update_valid), 32'd0);

    // Predicted not-taken, actually taken.
    push(32'h200, 1'b0, 32'h0);
    resolve(1'b1, 32'h260);
    check("t2_mispredict", 32'(mispredict), 32'd1);
    check("t2_redirect", redirect_pc, 32'h260);
    check("t2_update_addr", update_addr, 32'h200);
    check("t2_pending", 32'(pending), 32'd0);
    @(negedge clk);
    check("t2_mispredict_drop", 32'(mispredict), 32'd0);
    check("t2_redirect_hold", redirect_pc, 32'h260);

    // Predicted taken, actually not taken: fall-through redirect.
    push(32'h300, 1'b1, 32'h320);
    resolve(1'b0, 32'h0);
    check("t3_mispredict", 32'(mispredict), 32'd1);
    check("t3_redirect", redirect_pc, 32'h304);
    check("t3_update_taken", 32'(update_taken), 32'd0);

    // Taken both ways but wrong target.
    push(32'h500, 1'b1, 32'h540);
    resolve(1'b1, 32'h580);
    check("t3b_mispredict", 32'(mispredict), 32'd1);
    check("t3b_redirect", redirect_pc, 32'h580);

    // Clean not-taken to move pointers off zero, so the fill below wraps.
    push(32'h600, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    check("t4_pre_mispredict", 32'(mispredict), 32'd0);
    check("t4_pre_addr", update_addr, 32'h600);
    check("t4_pre_redirect_hold", redirect_pc, 32'h580);

    // Fill, overflow attempt, then drain in order.
    for (int i = 0; i < 4; i++) push(wrap_pcs[i], 1'b0, 32'h0);
    check("t4_full_ready", 32'(pred_ready), 32'd0);
    check("t4_full_pending", 32'(pending), 32'd4);
    push(32'h1400, 1'b0, 32'h0);
    check("t4_overflow_pending", 32'(pending), 32'd4);
    for (int i = 0; i < 4; i++) begin
      resolve(1'b0, 32'h0);
      check($sformatf("t4_drain_addr%0d", i), update_addr, wrap_pcs[i]);
      check($sformatf("t4_drain_valid%0d", i), 32'(update_valid), 32'd1);
      check($sformatf("t4_drain_misp%0d", i), 32'(mispredict), 32'd0);
    end
    check("t4_drained_pending", 32'(pending), 32'd0);
    check("t4_drained_ready", 32'(pred_ready), 32'd1);

    // Concurrent push and clean pop keep occupancy.
    push(32'h700, 1'b0, 32'h0);
    push_and_resolve(32'h710, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t5_pp_addr", update_addr, 32'h700);
    check("t5_pp_pending", 32'(pending), 32'd1);
    resolve(1'b0, 32'h0);
    check("t5_pp_addr2", update_addr, 32'h710);
    check("t5_pp_pending2", 32'(pending), 32'd0);

    // Mispredict pop drops a concurrent push; then underflow.
    push(32'h800, 1'b1, 32'h840);
    push_and_resolve(32'h400, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t6_mispredict", 32'(mispredict), 32'd1);
    check("t6_redirect", redirect_pc, 32'h804);
    check("t6_pending", 32'(pending), 32'd0);
    resolve(1'b0, 32'h0);
    check("t6_underflow", 32'(underflow_err), 32'd1);
    check("t6_no_update", 32'(update_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("t6_underflow_sticky", 32'(underflow_err), 32'd1);

    // Asynchronous reset mid-stream.
    push(32'h900, 1'b0, 32'h0);
    push(32'h904, 1'b0, 32'h0);
    check("t7_pending_pre", 32'(pending), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_pending", 32'(pending), 32'd0);
    check("t7_rst_ready", 32'(pred_ready), 32'd1);
    check("t7_rst_underflow", 32'(underflow_err), 32'd0);
    check("t7_rst_redirect", redirect_pc, 32'd0);
    check("t7_rst_stat_res", 32'(stat_resolved), 32'd0);
    check("t7_rst_stat_mis", 32'(stat_mispred), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Three resolves, one mispredicted, for the statistics counters.
    push(32'hA00, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    push(32'hA10, 1'b1, 32'hA80);
    resolve(1'b1, 32'hA80);
    push(32'hA20, 1'b0, 32'h0);
    resolve(1'b1, 32'hAF0);
    check("t8_mispredict", 32'(mispredict), 32'd1);
    check("t8_redirect", redirect_pc, 32'hAF0);
    repeat (2) @(negedge clk);
`ifdef BRU_STATS_EN
    check("t8_stat_resolved", 32'(stat_resolved), 32'd3);
    check("t8_stat_mispred", 32'(stat_mispred), 32'd1);
`else
    check("t8_stat_resolved_off", 32'(stat_resolved), 32'd0);
    check("t8_stat_mispred_off", 32'(stat_mispred), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolution-side partner of the branch predictor.
- Records every prediction issued at decode in a small in-order queue.
- When execute/mem reports the actual outcome, pops the oldest entry and compares it against the outcome.
- Emits the predictor-table update strobe/address/decision, plus a mispredict flush with the corrected fetch PC.

Parameters:
- DEPTH, 4, number of in-flight predicted branches held; power of two, minimum 2.
- PC_INC, 4, fall-through increment added to the branch PC for a not-taken redirect.

Ports:
- clk  input  1  core clock; all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- pred_valid  input  1  decode issues a predicted branch this cycle.
- pred_ready  output  1  queue can accept; equals !full, registered-state derived.
- pred_pc  input  32  PC of the predicted branch.
- pred_taken  input  1  predictor decision.
- pred_target  input  32  predicted target address (pc + offset).
- resolve_valid  input  1  actual outcome available for the oldest branch.
- resolve_taken  input  1  actual branch decision.
- resolve_target  input  32  actual computed target.
- update_valid  output  1  one-cycle strobe to predictor table update (branch_mem_sig).
- update_addr  output  32  PC of resolved branch (update_branch_addr).
- update_taken  output  1  actual decision (actual_branch_decision).
- mispredict  output  1  one-cycle flush request.
- redirect_pc  output  32  corrected fetch PC, valid when mispredict=1.
- pending  output  log2(DEPTH)+1  current queue occupancy.
- underflow_err  output  1  sticky: resolve_valid seen while empty.
- stat_resolved  output  16  branch-resolution count (see Optional Feature).
- stat_mispred  output  16  mispredict count (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): queue empty, pointers 0, pending=0; all outputs 0 except pred_ready=1.
- Push: pred_valid && pred_ready writes {pred_pc, pred_taken, pred_target} at the write pointer. Pointer wraps modulo DEPTH. pred_valid while full is ignored; no state change.
- Pop: resolve_valid && !empty removes the oldest entry.
- Resolution outputs are registered; they appear the cycle after the pop (latency 1):
  - update_valid=1, update_addr=entry.pc, update_taken=resolve_taken.
  - mispredict=1 when (entry.taken != resolve_taken) or (entry.taken && resolve_taken && entry.target != resolve_target).
  - redirect_pc = resolve_taken ? resolve_target : entry.pc + PC_INC (32-bit wrap).
  - When mispredict=0, redirect_pc holds its previous value.
- Mispredict flush: in the pop cycle, the entire queue is cleared (pointers equalised, pending=0). A push in the same cycle is discarded as wrong-path.
- Simultaneous push and pop without mispredict: both occur, pending unchanged. This is legal only when not full, because pred_ready=!full.
- resolve_valid while empty: no pop, no update strobe, underflow_err set. It clears only on reset.
- All strobes last exactly one cycle; update_valid never asserts on two consecutive cycles unless resolve_valid is held with entries available.
- Reset asserted mid-operation: immediate return to reset values; queued entries are lost.

Optional Feature:
- Macro: BRU_STATS_EN.
- When defined: stat_resolved increments on every update_valid; stat_mispred increments on every mispredict. Both are 16-bit, saturate at 16'hFFFF, and are cleared by reset.
- When not defined: counters are not built and both ports are tied to 0; the port list is unchanged.

Decomposition:
- Package bru_pkg holds:
  - typedef bru_entry_t {pc[31:0], taken, target[31:0]};
  - default DEPTH and PC_INC constants;
  - pointer-width function clog2.
- Sub-module bru_fifo: circular buffer with push, pop, synchronous flush, full/empty, count; instantiated once.
- Comparison, redirect and stats logic live in the top module.

Test Plan:
- Reset then push pc=0x100, taken=1, target=0x140; resolve taken=1, target=0x140 -> next cycle update_valid=1, update_addr=0x100, update_taken=1, mispredict=0.
- Push pc=0x200, taken=0; resolve taken=1, target=0x260 -> mispredict=1, redirect_pc=0x260, pending=0 after.
- Push pc=0x300, taken=1, target=0x320; resolve taken=0 -> mispredict=1, redirect_pc=0x304.
- Push 4 entries -> pred_ready=0. A 5th push is ignored. Then 4 clean resolves return update_addr in push order across pointer wrap.
- Mispredict pop with concurrent push pc=0x400 -> push dropped, pending=0. A later resolve_valid sets underflow_err=1 with no update_valid.
- With BRU_STATS_EN: 3 resolves, 1 mispredict -> stat_resolved=3, stat_mispred=1. Assert rst_n low mid-stream -> all counters and pending return to 0 immediately.
